pipeline_chain: RTL and testbench

PIPELINE_CHAIN -- requirements
Module: pipeline_chain

---
 rtl/pipeline_chain.sv | 112 +++++++++++
 tb/tb_pipeline_chain.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_chain.sv
// Elastic register chain with per-stage flush, bubble collapse and youngest-match
// tag forwarding. Stage 0 is the youngest entry, stage STAGES-1 drives the output.
module pipeline_chain #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int STAGES = 5
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [DATA_W-1:0]           i_in_data,
    input  logic [TAG_W-1:0]            i_in_tag,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [DATA_W-1:0]           o_out_data,
    output logic [TAG_W-1:0]            o_out_tag,
    input  logic [STAGES-1:0]           i_flush_mask,
    input  logic [TAG_W-1:0]            i_q_tag,
    output logic                        o_q_hit,
    output logic [DATA_W-1:0]           o_q_data,
    output logic [$clog2(STAGES)-1:0]   o_q_stage,
    output logic [$clog2(STAGES+1)-1:0] o_count
);
    localparam int SW = $clog2(STAGES);
    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] r_valid;
    logic [DATA_W-1:0] r_data [STAGES];
    logic [TAG_W-1:0]  r_tag  [STAGES];
    logic [CW-1:0]     r_count;

    logic [STAGES-1:0] w_live;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_valid_nxt;
    logic [CW-1:0]     w_count_nxt;

    // Reset masks liveness so the outputs read idle while rst is held.
    assign w_live = r_valid & ~i_flush_mask & {STAGES{~i_rst}};

    always_comb begin
        logic v_adv;
        w_adv = '0;
        v_adv = i_out_ready | ~w_live[STAGES-1];
        w_adv[STAGES-1] = v_adv;
        for (int i = STAGES - 2; i >= 0; i--) begin
            v_adv    = v_adv | ~w_live[i+1];
            w_adv[i] = v_adv;
        end
    end

    assign o_in_ready  = ~w_live[0] | w_adv[0];
    assign o_out_valid = w_live[STAGES-1];
    assign o_out_data  = i_rst ? '0 : r_data[STAGES-1];
    assign o_out_tag   = i_rst ? '0 : r_tag[STAGES-1];
    assign o_count     = r_count;

    // A stage that does not advance keeps only its live content, so a flush
    // of held content drops it while a flushed stage that advances is refilled.
    always_comb begin
        w_valid_nxt    = '0;
        w_valid_nxt[0] = o_in_ready ? i_in_valid : w_live[0];
        for (int i = 1; i < STAGES; i++) begin
            w_valid_nxt[i] = w_adv[i-1] ? w_live[i-1] : w_live[i];
        end
    end

    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < STAGES; i++) begin
            w_count_nxt = w_count_nxt + CW'(w_valid_nxt[i]);
        end
    end

    // Scan oldest to youngest so the lowest matching index is the one left standing.
    always_comb begin
        o_q_hit   = 1'b0;
        o_q_data  = '0;
        o_q_stage = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (w_live[i] && (r_tag[i] == i_q_tag) && (i_q_tag != '0)) begin
                o_q_hit   = 1'b1;
                o_q_data  = r_data[i];
                o_q_stage = SW'(i);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_count <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_count <= w_count_nxt;
            if (o_in_ready) begin
                r_data[0] <= i_in_data;
                r_tag[0]  <= i_in_tag;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_adv[i-1]) begin
                    r_data[i] <= r_data[i-1];
                    r_tag[i]  <= r_tag[i-1];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipeline_chain.sv
// Directed bench for pipeline_chain (STAGES=5, DATA_W=32, TAG_W=5): streaming,
// stall, bubble collapse, forwarding, flush corner cases and reset behaviour.
module tb_pipeline_chain;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [4:0]  flush_mask;
    logic [4:0]  q_tag;
    logic        q_hit;
    logic [31:0] q_data;
    logic [2:0]  q_stage;
    logic [2:0]  count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipeline_chain #(.DATA_W(32), .TAG_W(5), .STAGES(5)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_in_data(in_data), .i_in_tag(in_tag),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_tag(out_tag),
        .i_flush_mask(flush_mask), .i_q_tag(q_tag),
        .o_q_hit(q_hit), .o_q_data(q_data), .o_q_stage(q_stage),
        .o_count(count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] t);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; in_tag = 5'd3;
        out_ready = 1'b1; flush_mask = '0; q_tag = 5'd3;
        tick(); tick();
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'h0 || out_tag !== 5'h0) $display("FAIL rst_out_data got=%h/%h exp=0/0", out_data, out_tag); else pass_cnt++;
        total_cnt++; if (q_hit !== 1'b0 || q_data !== 32'h0 || q_stage !== 3'd0) $display("FAIL rst_q got=%b/%h/%0d exp=0/0/0", q_hit, q_data, q_stage); else pass_cnt++;
        total_cnt++; if (count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", count); else pass_cnt++;
        rst = 1'b0; in_valid = 1'b0;
        tick();
        total_cnt++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_release got=%0d/%b/%b exp=0/0/1", count, out_valid, in_ready); else pass_cnt++;
    endtask

    task automatic test_stream();
        int peak = 0;
        int exp_cnt, exited;
        logic exp_v;
        out_ready = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            if (c - 1 < 10) begin
                in_valid = 1'b1; in_data = 32'hA0 + 32'(c - 1); in_tag = 5'(c);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            exp_v  = (c >= 5) && (c <= 14);
            exited = (c - 5 < 0) ? 0 : ((c - 5 > 10) ? 10 : c - 5);
            exp_cnt = ((c < 10) ? c : 10) - exited;
            if (int'(count) > peak) peak = int'(count);
            total_cnt++; if (out_valid !== exp_v) $display("FAIL stream_valid c=%0d got=%b exp=%b", c, out_valid, exp_v); else pass_cnt++;
            if (exp_v) begin
                total_cnt++;
                if (out_data !== 32'hA0 + 32'(c - 5) || out_tag !== 5'(c - 4))
                    $display("FAIL stream_data c=%0d got=%h/%0d exp=%h/%0d", c, out_data, out_tag, 32'hA0 + 32'(c - 5), c - 4);
                else pass_cnt++;
            end
            total_cnt++; if (count !== 3'(exp_cnt)) $display("FAIL stream_count c=%0d got=%0d exp=%0d", c, count, exp_cnt); else pass_cnt++;
            total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready); else pass_cnt++;
        end
        in_valid = 1'b0;
        total_cnt++; if (peak != 5) $display("FAIL stream_peak got=%0d exp=5", peak); else pass_cnt++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) push(32'hB0 + 32'(j), 5'(11 + j));
        in_valid = 1'b1; in_data = 32'hB9; in_tag = 5'd19;
        for (int s = 0; s < 3; s++) begin
            #1;
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready s=%0d got=%b exp=0", s, in_ready); else pass_cnt++;
            total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'hB0 || out_tag !== 5'd11) $display("FAIL stall_out s=%0d got=%b/%h/%0d exp=1/b0/11", s, out_valid, out_data, out_tag); else pass_cnt++;
            total_cnt++; if (count !== 3'd5) $display("FAIL stall_count s=%0d got=%0d exp=5", s, count); else pass_cnt++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        for (int e = 0; e < 5; e++) begin
            total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'hB0 + 32'(e)) $display("FAIL stall_drain e=%0d got=%b/%h exp=1/%h", e, out_valid, out_data, 32'hB0 + 32'(e)); else pass_cnt++;
            tick();
        end
        total_cnt++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL stall_empty got=%b/%0d exp=0/0", out_valid, count); else pass_cnt++;
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        push(32'hC0, 5'd20);
        for (int k = 0; k < 4; k++) tick();
        push(32'hC1, 5'd21);
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'hC0) $display("FAIL bubble_out got=%b/%h exp=1/c0", out_valid, out_data); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1 || count !== 3'd2) $display("FAIL bubble_ready got=%b/%0d exp=1/2", in_ready, count); else pass_cnt++;
        push(32'hC2, 5'd22);
        q_tag = 5'd21; #1;
        total_cnt++; if (q_hit !== 1'b1 || q_stage !== 3'd1 || q_data !== 32'hC1) $display("FAIL bubble_advance got=%b/%0d/%h exp=1/1/c1", q_hit, q_stage, q_data); else pass_cnt++;
        q_tag = 5'd22; #1;
        total_cnt++; if (q_hit !== 1'b1 || q_stage !== 3'd0 || q_data !== 32'hC2) $display("FAIL bubble_load got=%b/%0d/%h exp=1/0/c2", q_hit, q_stage, q_data); else pass_cnt++;
        total_cnt++; if (count !== 3'd3) $display("FAIL bubble_count got=%0d exp=3", count); else pass_cnt++;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        total_cnt++; if (count !== 3'd0) $display("FAIL bubble_drain got=%0d exp=0", count); else pass_cnt++;
    endtask

    task automatic test_forward();
        out_ready = 1'b0;
        push(32'h33, 5'd7);
        push(32'h22, 5'd0);
        push(32'h11, 5'd7);
        push(32'h44, 5'd4);
        q_tag = 5'd7; #1;
        total_cnt++; if (q_hit !== 1'b1 || q_data !== 32'h11 || q_stage !== 3'd1) $display("FAIL fwd_youngest got=%b/%h/%0d exp=1/11/1", q_hit, q_data, q_stage); else pass_cnt++;
        q_tag = 5'd0; #1;
        total_cnt++; if (q_hit !== 1'b0 || q_data !== 32'h0 || q_stage !== 3'd0) $display("FAIL fwd_tag0 got=%b/%h/%0d exp=0/0/0", q_hit, q_data, q_stage); else pass_cnt++;
        q_tag = 5'd9; #1;
        total_cnt++; if (q_hit !== 1'b0) $display("FAIL fwd_miss got=%b exp=0", q_hit); else pass_cnt++;
        q_tag = 5'd4; #1;
        total_cnt++; if (q_hit !== 1'b1 || q_data !== 32'h44 || q_stage !== 3'd0) $display("FAIL fwd_stage0 got=%b/%h/%0d exp=1/44/0", q_hit, q_data, q_stage); else pass_cnt++;
        q_tag = 5'd7; flush_mask = 5'b00010; #1;
        total_cnt++; if (q_hit !== 1'b1 || q_data !== 32'h33 || q_stage !== 3'd3) $display("FAIL fwd_flushed got=%b/%h/%0d exp=1/33/3", q_hit, q_data, q_stage); else pass_cnt++;
        flush_mask = '0; #1;
    endtask

    task automatic test_midreset();
        logic seen = 1'b0;
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hEE; in_tag = 5'd7;
        out_ready = 1'b1; q_tag = 5'd7; #1;
        total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || q_hit !== 1'b0) $display("FAIL midrst_during got=%b/%b/%b exp=1/0/0", in_ready, out_valid, q_hit); else pass_cnt++;
        tick();
        total_cnt++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midrst_after got=%0d/%b/%b exp=0/0/1", count, out_valid, in_ready); else pass_cnt++;
        rst = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid) seen = 1'b1;
            tick();
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL midrst_emerge got=%b exp=0", seen); else pass_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) push(32'hD0 + 32'(j), 5'(j + 1));
        flush_mask = 5'b00111; out_ready = 1'b1; #1;
        total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'hD0 || count !== 3'd5) $display("FAIL flush_pre got=%b/%h/%0d exp=1/d0/5", out_valid, out_data, count); else pass_cnt++;
        tick();
        flush_mask = '0; #1;
        total_cnt++; if (count !== 3'd1 || out_valid !== 1'b1 || out_data !== 32'hD1 || out_tag !== 5'd2) $display("FAIL flush_survivor got=%0d/%b/%h/%0d exp=1/1/d1/2", count, out_valid, out_data, out_tag); else pass_cnt++;
        tick();
        total_cnt++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL flush_empty got=%0d/%b exp=0/0", count, out_valid); else pass_cnt++;
    endtask

    task automatic test_flush_edge();
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) push(32'hF0 + 32'(j), 5'(j + 1));
        flush_mask = 5'b00001; in_valid = 1'b1; in_data = 32'hF5; in_tag = 5'd9; #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL flushload_ready got=%b exp=1", in_ready); else pass_cnt++;
        tick();
        flush_mask = '0; in_valid = 1'b0; q_tag = 5'd9; #1;
        total_cnt++; if (count !== 3'd5 || q_hit !== 1'b1 || q_stage !== 3'd0 || q_data !== 32'hF5) $display("FAIL flushload_new got=%0d/%b/%0d/%h exp=5/1/0/f5", count, q_hit, q_stage, q_data); else pass_cnt++;
        q_tag = 5'd5; #1;
        total_cnt++; if (q_hit !== 1'b0) $display("FAIL flushload_old got=%b exp=0", q_hit); else pass_cnt++;
        flush_mask = 5'b10000; out_ready = 1'b1; #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flushlast_valid got=%b exp=0", out_valid); else pass_cnt++;
        tick();
        flush_mask = '0; out_ready = 1'b0; #1;
        total_cnt++; if (count !== 3'd4 || out_data !== 32'hF1) $display("FAIL flushlast_next got=%0d/%h exp=4/f1", count, out_data); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_tag = '0;
        out_ready = 1'b0; flush_mask = '0; q_tag = '0;
        #2;
        test_reset();
        test_stream();
        test_stall();
        test_bubble();
        test_forward();
        test_midreset();
        test_flush();
        test_flush_edge();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
